// File: rtl/link_cmd_arbiter.sv
// link_cmd_arbiter: shares the host UART transmitter between the frame
// byte stream and locally generated stats responses, and decodes host
// commands into trace width and stream enable settings.
//
// Ports:
//   clkOut, rst       clock, synchronous active-high reset
//   RxedEvent, RxByte host command byte strobe and value
//   FrameDataVal/Ready/Next  frame serializer handshake (Next is an accept)
//   TxFree, TxByte, TxStrobe transmitter handshake
//   TotalFrames, LostFrames  counters captured for stats responses
//   Width, StreamEn   trace width and streaming enable settings
//   CmdDropped        pulse when a stats request is discarded
module link_cmd_arbiter #(
  parameter int         FRAME_BYTES = 16,
  parameter logic [7:0] RESP_HDR    = 8'hC5,
  parameter logic [1:0] RESET_WIDTH = 2'b11
) (
  input  logic        clkOut,
  input  logic        rst,
  input  logic        RxedEvent,
  input  logic [7:0]  RxByte,
  input  logic [7:0]  FrameDataVal,
  input  logic        FrameDataReady,
  output logic        FrameDataNext,
  input  logic        TxFree,
  output logic [7:0]  TxByte,
  output logic        TxStrobe,
  input  logic [31:0] TotalFrames,
  input  logic [15:0] LostFrames,
  output logic [1:0]  Width,
  output logic        StreamEn,
  output logic        CmdDropped
);

  localparam int CW =
    (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(FRAME_BYTES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GAP  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] RGAP = 2'd3;

  // Response index runs 0..6; reaching 7 means all bytes are out.
  localparam logic [2:0] RESP_END = 3'd7;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic          pending;
  logic          req_en;
  logic [2:0]    resp_idx;
  logic [31:0]   snap_total;
  logic [15:0]   snap_lost;
  logic [7:0]    resp_byte;
  logic          at_bound;
  logic          resp_go;
  logic          frame_go;

  assign at_bound = (count == '0);

  // A pending response wins over frame data, but only between frames.
  assign resp_go = (state == IDLE) && pending &&
                   at_bound && TxFree;

  assign frame_go = (state == IDLE) && !resp_go &&
                    StreamEn && FrameDataReady && TxFree;

  assign FrameDataNext = frame_go;

  always_comb begin
    resp_byte = RESP_HDR;
    case (resp_idx)
      3'd1:    resp_byte = snap_total[7:0];
      3'd2:    resp_byte = snap_total[15:8];
      3'd3:    resp_byte = snap_total[23:16];
      3'd4:    resp_byte = snap_total[31:24];
      3'd5:    resp_byte = snap_lost[7:0];
      3'd6:    resp_byte = snap_lost[15:8];
      default: resp_byte = RESP_HDR;
    endcase
  end

  always_ff @(posedge clkOut) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      pending    <= 1'b0;
      req_en     <= 1'b1;
      resp_idx   <= '0;
      snap_total <= '0;
      snap_lost  <= '0;
      Width      <= RESET_WIDTH;
      StreamEn   <= 1'b1;
      TxByte     <= '0;
      TxStrobe   <= 1'b0;
      CmdDropped <= 1'b0;
    end else begin
      TxStrobe   <= 1'b0;
      CmdDropped <= 1'b0;

      if (frame_go)
        count <= (count == LAST) ? '0 : count + 1'b1;

      // Hold the enable while the first byte of a frame is being
      // accepted so that a started frame can always finish.
      if (at_bound && !frame_go)
        StreamEn <= req_en;

      if (RxedEvent) begin
        case (RxByte[7:4])
          4'h1: begin
            if (RxByte[3:2] == 2'b00)
              Width <= RxByte[1:0];
          end
          4'h2: begin
            if (!pending) begin
              snap_total <= TotalFrames;
              snap_lost  <= LostFrames;
              resp_idx   <= '0;
              pending    <= 1'b1;
            end else begin
              CmdDropped <= 1'b1;
            end
          end
          4'h3: req_en <= RxByte[0];
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (resp_go) begin
            TxByte   <= resp_byte;
            TxStrobe <= 1'b1;
            resp_idx <= resp_idx + 1'b1;
            state    <= RESP;
          end else if (frame_go) begin
            TxByte   <= FrameDataVal;
            TxStrobe <= 1'b1;
            state    <= GAP;
          end
        end
        GAP:  state <= IDLE;
        RESP: state <= RGAP;
        RGAP: begin
          if (resp_idx == RESP_END) begin
            pending <= 1'b0;
            state   <= IDLE;
          end else if (TxFree) begin
            TxByte   <= resp_byte;
            TxStrobe <= 1'b1;
            resp_idx <= resp_idx + 1'b1;
            state    <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_link_cmd_arbiter.sv
// tb_link_cmd_arbiter: directed self-checking bench for
// link_cmd_arbiter.
module tb_link_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_ev;
  logic [7:0]  rx_byte;
  logic [7:0]  frame_val;
  logic        frame_ready;
  logic        frame_next;
  logic        tx_free;
  logic [7:0]  tx_byte;
  logic        tx_strobe;
  logic [31:0] total;
  logic [15:0] lost;
  logic [1:0]  width;
  logic        stream_en;
  logic        cmd_dropped;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc      = 0;

  logic [7:0] log_b[$];
  int         log_c[$];

  always #5 clk = ~clk;

  link_cmd_arbiter dut (
    .clkOut        (clk),
    .rst           (rst),
    .RxedEvent     (rx_ev),
    .RxByte        (rx_byte),
    .FrameDataVal  (frame_val),
    .FrameDataReady(frame_ready),
    .FrameDataNext (frame_next),
    .TxFree        (tx_free),
    .TxByte        (tx_byte),
    .TxStrobe      (tx_strobe),
    .TotalFrames   (total),
    .LostFrames    (lost),
    .Width         (width),
    .StreamEn      (stream_en),
    .CmdDropped    (cmd_dropped)
  );

  // Serializer model: frame byte value is its index since reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) acc <= 0;
    else if (frame_next) acc <= acc + 1;
  end

  assign frame_val = acc[7:0];

  always @(negedge clk)
    if (tx_strobe) begin
      log_b.push_back(tx_byte);
      log_c.push_back(cyc);
    end

  function automatic logic [7:0] rexp(
    input logic [31:0] t, input logic [15:0] l,
    input int i);
    case (i)
      0: return 8'hC5;
      1: return t[7:0];
      2: return t[15:8];
      3: return t[23:16];
      4: return t[31:24];
      5: return l[7:0];
      default: return l[15:8];
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_ev   = 1'b1;
    rx_byte = b;
    tick();
    rx_ev   = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget,
                          output bit ok);
    int k = 0;
    while (log_b.size() < n && k < budget) begin
      tick();
      k++;
    end
    ok = (log_b.size() >= n);
  endtask

  task automatic wait_cnt(input int m, input int budget,
                          output bit ok);
    int k = 0;
    while ((acc % 16) != m && k < budget) begin
      tick();
      k++;
    end
    ok = ((acc % 16) == m);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_ev = 1'b0; rx_byte = 8'h00;
    frame_ready = 1'b0; tx_free = 1'b1;
    total = '0; lost = '0;
    repeat (3) tick();
    checks++;
    if (width !== 2'b11) begin
      failures++;
      $display("FAIL rst_width got=%b exp=11", width);
    end
    checks++;
    if (stream_en !== 1'b1) begin
      failures++;
      $display("FAIL rst_en got=%b exp=1", stream_en);
    end
    checks++;
    if (tx_strobe !== 1'b0) begin
      failures++;
      $display("FAIL rst_strobe got=%b exp=0", tx_strobe);
    end
    checks++;
    if (tx_byte !== 8'h00) begin
      failures++;
      $display("FAIL rst_byte got=%h exp=00", tx_byte);
    end
    checks++;
    if (frame_next !== 1'b0) begin
      failures++;
      $display("FAIL rst_next got=%b exp=0", frame_next);
    end
    checks++;
    if (cmd_dropped !== 1'b0) begin
      failures++;
      $display("FAIL rst_drop got=%b exp=0", cmd_dropped);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_width();
    logic [7:0] cmd[4]  = '{8'h12, 8'h16, 8'h10, 8'h13};
    logic [1:0] want[4] = '{2'b10, 2'b10, 2'b00, 2'b11};
    for (int i = 0; i < 4; i++) begin
      send(cmd[i]);
      checks++;
      if (width !== want[i]) begin
        failures++;
        $display("FAIL width_%h got=%b exp=%b",
                 cmd[i], width, want[i]);
      end
    end
  endtask

  task automatic test_stats();
    logic [7:0] want[7] = '{8'hC5, 8'h04, 8'h03,
                            8'h02, 8'h01, 8'h06, 8'h05};
    int s = log_b.size();
    bit ok;
    total = 32'h01020304;
    lost  = 16'h0506;
    send(8'h20);
    total = 32'hDEADBEEF;
    lost  = 16'hFFFF;
    wait_log(s + 7, 40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stats_timeout got=%0d exp=7",
               log_b.size() - s);
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (log_b[s+i] !== want[i]) begin
          failures++;
          $display("FAIL stats_b%0d got=%h exp=%h",
                   i, log_b[s+i], want[i]);
        end
      end
      for (int i = 1; i < 7; i++) begin
        checks++;
        if (log_c[s+i] - log_c[s+i-1] != 2) begin
          failures++;
          $display("FAIL stats_gap%0d got=%0d exp=2",
                   i, log_c[s+i] - log_c[s+i-1]);
        end
      end
    end
    repeat (10) tick();
    checks++;
    if (log_b.size() != s + 7) begin
      failures++;
      $display("FAIL stats_count got=%0d exp=7",
               log_b.size() - s);
    end
  endtask

  task automatic test_frame_resp();
    int a, s;
    bit ok;
    logic [7:0] w;
    frame_ready = 1'b1;
    total = 32'hAABBCCDD;
    lost  = 16'h1122;
    wait_cnt(5, 80, ok);
    a = acc;
    s = log_b.size();
    send(8'h20);
    total = '0;
    lost  = '0;
    wait_log(s + 19, 120, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL fr_timeout got=%0d exp=19",
               log_b.size() - s);
    end else begin
      for (int i = 0; i < 19; i++) begin
        if (i < 11)
          w = 8'(a + i);
        else if (i < 18)
          w = rexp(32'hAABBCCDD, 16'h1122, i - 11);
        else
          w = 8'(a + 11);
        checks++;
        if (log_b[s+i] !== w) begin
          failures++;
          $display("FAIL fr_b%0d got=%h exp=%h",
                   i, log_b[s+i], w);
        end
      end
    end
  endtask

  task automatic test_enable();
    int a;
    bit ok;
    wait_cnt(3, 80, ok);
    a = acc;
    send(8'h30);
    repeat (60) tick();
    checks++;
    if (acc != a + 13) begin
      failures++;
      $display("FAIL en_stop got=%0d exp=%0d", acc, a + 13);
    end
    checks++;
    if (stream_en !== 1'b0) begin
      failures++;
      $display("FAIL en_off got=%b exp=0", stream_en);
    end
    send(8'h31);
    repeat (10) tick();
    checks++;
    if (stream_en !== 1'b1) begin
      failures++;
      $display("FAIL en_on got=%b exp=1", stream_en);
    end
    checks++;
    if (acc <= a + 13) begin
      failures++;
      $display("FAIL en_resume got=%0d exp>%0d", acc, a + 13);
    end
    send(8'h30);
    repeat (60) tick();
    checks++;
    if ((acc % 16) != 0) begin
      failures++;
      $display("FAIL en_drain got=%0d exp=0", acc % 16);
    end
    frame_ready = 1'b0;
    send(8'h31);
    repeat (3) tick();
  endtask

  task automatic test_drop_stall();
    int s = log_b.size();
    bit ok;
    total = 32'h11223344;
    lost  = 16'h5566;
    send(8'h20);
    wait_log(s + 1, 20, ok);
    send(8'h20);
    checks++;
    if (cmd_dropped !== 1'b1) begin
      failures++;
      $display("FAIL drop_pulse got=%b exp=1", cmd_dropped);
    end
    tick();
    checks++;
    if (cmd_dropped !== 1'b0) begin
      failures++;
      $display("FAIL drop_clear got=%b exp=0", cmd_dropped);
    end
    wait_log(s + 2, 20, ok);
    tx_free = 1'b0;
    repeat (50) tick();
    checks++;
    if (log_b.size() != s + 2) begin
      failures++;
      $display("FAIL stall_count got=%0d exp=2",
               log_b.size() - s);
    end
    tx_free = 1'b1;
    wait_log(s + 7, 40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_timeout got=%0d exp=7",
               log_b.size() - s);
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (log_b[s+i] !==
            rexp(32'h11223344, 16'h5566, i)) begin
          failures++;
          $display("FAIL stall_b%0d got=%h exp=%h", i,
                   log_b[s+i],
                   rexp(32'h11223344, 16'h5566, i));
        end
      end
    end
    repeat (30) tick();
    checks++;
    if (log_b.size() != s + 7) begin
      failures++;
      $display("FAIL drop_count got=%0d exp=7",
               log_b.size() - s);
    end
  endtask

  task automatic test_reset_mid();
    int s, s2;
    bit ok;
    send(8'h11);
    s = log_b.size();
    total = 32'hA1B2C3D4;
    lost  = 16'hE5F6;
    send(8'h20);
    wait_log(s + 3, 20, ok);
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (tx_strobe !== 1'b0 || tx_byte !== 8'h00) begin
      failures++;
      $display("FAIL mid_tx got=%b/%h exp=0/00",
               tx_strobe, tx_byte);
    end
    checks++;
    if (width !== 2'b11 || stream_en !== 1'b1) begin
      failures++;
      $display("FAIL mid_cfg got=%b/%b exp=11/1",
               width, stream_en);
    end
    checks++;
    if (cmd_dropped !== 1'b0 || frame_next !== 1'b0) begin
      failures++;
      $display("FAIL mid_ctl got=%b/%b exp=0/0",
               cmd_dropped, frame_next);
    end
    rst = 1'b0;
    repeat (30) tick();
    checks++;
    if (log_b.size() != s + 3) begin
      failures++;
      $display("FAIL mid_abort got=%0d exp=3",
               log_b.size() - s);
    end
    s2 = log_b.size();
    total = 32'h0BADCAFE;
    lost  = 16'h1357;
    send(8'h20);
    wait_log(s2 + 7, 40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL mid_timeout got=%0d exp=7",
               log_b.size() - s2);
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (log_b[s2+i] !==
            rexp(32'h0BADCAFE, 16'h1357, i)) begin
          failures++;
          $display("FAIL mid_b%0d got=%h exp=%h", i,
                   log_b[s2+i],
                   rexp(32'h0BADCAFE, 16'h1357, i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_width();
    test_stats();
    test_frame_resp();
    test_enable();
    test_drop_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
